// File: rtl/int_ctrl_pkg.sv
// Shared types, constants and the priority-pick helper for the interrupt controller.
// Consumers: int_ctrl, int_prio_enc.
package int_ctrl_pkg;

    localparam int         NUM_SRC      = 8;
    localparam logic [7:0] VEC_BASE_DEF = 8'h40;
    localparam int         HOLD_CYC_DEF = 3;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_READ = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_INSVC = 2'd2
    } svc_state_t;

    // First set bit of req scanning upward from start (wrapping); 0 when req is empty.
    function automatic logic [2:0] prio_pick(input logic [7:0] req, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        prio_pick = 3'd0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = start + 3'(i);
            if (!found && req[idx]) begin
                prio_pick = idx;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational 8-way priority encoder with a wrapping start pointer.
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] start,
    output logic [2:0] idx,
    output logic       valid
);

    assign idx   = prio_pick(req, start);
    assign valid = |req;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: fetches capture-block events, masks, arbitrates and runs the CPU handshake.
// Optional build macro INT_CTRL_PRIO_ROTATE_EN selects rotating instead of fixed priority.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = VEC_BASE_DEF,
    parameter int         HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] intreg,
    output logic       oping,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    output logic [7:0] mask,
    output logic       irq,
    output logic [7:0] vector,
    input  logic       irq_ack,
    input  logic       eoi,
    output logic [7:0] in_service
);

    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    fetch_state_t      fetch_state_r;
    fetch_state_t      fetch_next_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_next_s;
    logic              oping_r;

    svc_state_t        svc_state_r;
    svc_state_t        svc_next_s;
    logic [7:0]        pend_r;
    logic [7:0]        pend_set_s;
    logic [7:0]        pend_clr_s;
    logic [7:0]        mask_r;
    logic [7:0]        elig_s;
    logic [2:0]        win_r;
    logic [2:0]        win_s;
    logic              win_valid_s;
    logic              ack_take_s;
    logic [7:0]        vector_r;
    logic              irq_r;
    logic [7:0]        in_service_r;
    logic [2:0]        ptr_s;

    assign oping      = oping_r;
    assign mask       = mask_r;
    assign irq        = irq_r;
    assign vector     = vector_r;
    assign in_service = in_service_r;

    assign elig_s = pend_r & ~mask_r;

    int_prio_enc u_prio_enc (
        .req   (elig_s),
        .start (ptr_s),
        .idx   (win_s),
        .valid (win_valid_s)
    );

`ifdef INT_CTRL_PRIO_ROTATE_EN
    logic [2:0] ptr_r;

    // Rotation pointer: the source after the one just accepted becomes highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 3'd0;
        end else if (ack_take_s) begin
            ptr_r <= win_r + 3'd1;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = 3'd0;
`endif

    // Fetch FSM next state; intreg is ignored while the capture block reloads.
    always_comb begin
        fetch_next_s    = fetch_state_r;
        hold_cnt_next_s = hold_cnt_r;
        pend_set_s      = 8'h00;
        case (fetch_state_r)
            F_IDLE: begin
                if (intreg != 8'hff) begin
                    fetch_next_s = F_READ;
                end else begin
                    fetch_next_s = F_IDLE;
                end
            end
            F_READ: begin
                pend_set_s      = ~intreg;
                hold_cnt_next_s = {HOLD_W{1'b0}};
                fetch_next_s    = F_HOLD;
            end
            F_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    fetch_next_s = F_IDLE;
                end else begin
                    hold_cnt_next_s = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                fetch_next_s = F_IDLE;
            end
        endcase
    end

    // Fetch FSM state, hold counter and the registered read window.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_state_r <= F_IDLE;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            oping_r       <= 1'b0;
        end else begin
            fetch_state_r <= fetch_next_s;
            hold_cnt_r    <= hold_cnt_next_s;
            oping_r       <= (fetch_next_s == F_READ);
        end
    end

    // Service FSM next state; a mask on the winner withdraws the request even against a same-cycle ack.
    always_comb begin
        svc_next_s = svc_state_r;
        pend_clr_s = 8'h00;
        ack_take_s = 1'b0;
        case (svc_state_r)
            S_IDLE: begin
                if (win_valid_s) begin
                    svc_next_s = S_REQ;
                end else begin
                    svc_next_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mask_r[win_r]) begin
                    svc_next_s = S_IDLE;
                end else if (irq_ack) begin
                    svc_next_s = S_INSVC;
                    ack_take_s = 1'b1;
                    pend_clr_s = 8'h01 << win_r;
                end else begin
                    svc_next_s = S_REQ;
                end
            end
            S_INSVC: begin
                if (eoi) begin
                    svc_next_s = S_IDLE;
                end else begin
                    svc_next_s = S_INSVC;
                end
            end
            default: begin
                svc_next_s = S_IDLE;
            end
        endcase
    end

    // Service state, pending/mask registers and the CPU-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            svc_state_r  <= S_IDLE;
            pend_r       <= 8'h00;
            mask_r       <= 8'hff;
            win_r        <= 3'd0;
            vector_r     <= 8'h00;
            irq_r        <= 1'b0;
            in_service_r <= 8'h00;
        end else begin
            svc_state_r <= svc_next_s;
            // Set is applied after clear so a same-cycle fetch keeps the bit pending.
            pend_r      <= (pend_r & ~pend_clr_s) | pend_set_s;
            mask_r      <= mask_we ? mask_wdata : mask_r;
            irq_r       <= (svc_next_s == S_REQ);
            if (svc_state_r == S_IDLE && win_valid_s) begin
                win_r    <= win_s;
                vector_r <= VEC_BASE + {5'b00000, win_s};
            end
            if (ack_take_s) begin
                in_service_r <= 8'h01 << win_r;
            end else if (svc_next_s != S_INSVC) begin
                in_service_r <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl plus hand-written multi-cycle sequences.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] intreg;
    logic       oping;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic       irq;
    logic [7:0] vector;
    logic       irq_ack;
    logic       eoi;
    logic [7:0] in_service;

    int checks = 0;
    int errors = 0;

    int_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .intreg     (intreg),
        .oping      (oping),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .irq        (irq),
        .vector     (vector),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] intreg;
        logic       mask_we;
        logic [7:0] mask_wdata;
        logic       ack;
        logic       eoi;
        logic       exp_irq;
        logic [7:0] exp_vec;
        logic       exp_oping;
        logic [7:0] exp_insvc;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(input logic [7:0] ir, input logic we, input logic [7:0] wd,
                                input logic ak, input logic eo, input logic xi, input logic [7:0] xv,
                                input logic xo, input logic [7:0] xs, input logic [7:0] xm);
        vec_t v;
        v.intreg = ir; v.mask_we = we; v.mask_wdata = wd; v.ack = ak; v.eoi = eo;
        v.exp_irq = xi; v.exp_vec = xv; v.exp_oping = xo; v.exp_insvc = xs; v.exp_mask = xm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string name);
        int t;
        t = 0;
        while (irq !== 1'b1 && t < 20) begin
            cyc();
            t++;
        end
        chk(name, {7'd0, irq}, 8'h01);
    endtask

    logic [7:0] exp_served [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int last;
        int npulse;

`ifdef INT_CTRL_PRIO_ROTATE_EN
        exp_served[0] = 8'h40; exp_served[1] = 8'h47; exp_served[2] = 8'h40; exp_served[3] = 8'h47;
`else
        exp_served[0] = 8'h40; exp_served[1] = 8'h40; exp_served[2] = 8'h40; exp_served[3] = 8'h40;
`endif

        //                 intreg we  wdata  ak  eo   irq vec   op  insvc  mask
        tbl[0]  = mk(8'hff, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[1]  = mk(8'hfb, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
        tbl[2]  = mk(8'hfb, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[3]  = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 8'h00);
        tbl[4]  = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 8'h00);
        tbl[5]  = mk(8'hff, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 8'h00);
        tbl[6]  = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 8'h00);
        tbl[7]  = mk(8'hff, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 8'h00);
        tbl[8]  = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[9]  = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[10] = mk(8'hdd, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
        tbl[11] = mk(8'hdd, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[12] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'h00);
        tbl[13] = mk(8'hff, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 8'h00);
        tbl[14] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[15] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h45, 1'b0, 8'h00, 8'h00);
        tbl[16] = mk(8'hff, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h00);
        tbl[17] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[18] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[19] = mk(8'hf7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
        tbl[20] = mk(8'hf7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[21] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 8'h00, 8'h00);
        tbl[22] = mk(8'hff, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 8'h00, 8'h08);
        tbl[23] = mk(8'hff, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h08);
        tbl[24] = mk(8'hff, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[25] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 8'h00, 8'h00);
        tbl[26] = mk(8'hff, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 8'h00);
        tbl[27] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[28] = mk(8'hff, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        rst = 1'b1; intreg = 8'hff; mask_we = 1'b0; mask_wdata = 8'h00; irq_ack = 1'b0; eoi = 1'b0;
        cyc();
        cyc();
        chk("reset mask", mask, 8'hff);
        chk("reset irq", {7'd0, irq}, 8'h00);
        chk("reset oping", {7'd0, oping}, 8'h00);
        chk("reset vector", vector, 8'h00);
        chk("reset in_service", in_service, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            intreg = tbl[i].intreg; mask_we = tbl[i].mask_we; mask_wdata = tbl[i].mask_wdata;
            irq_ack = tbl[i].ack; eoi = tbl[i].eoi;
            cyc();
            chk($sformatf("row%0d irq", i), {7'd0, irq}, {7'd0, tbl[i].exp_irq});
            chk($sformatf("row%0d oping", i), {7'd0, oping}, {7'd0, tbl[i].exp_oping});
            chk($sformatf("row%0d in_service", i), in_service, tbl[i].exp_insvc);
            chk($sformatf("row%0d mask", i), mask, tbl[i].exp_mask);
            if (tbl[i].exp_irq) chk($sformatf("row%0d vector", i), vector, tbl[i].exp_vec);
        end
        mask_we = 1'b0; irq_ack = 1'b0; eoi = 1'b0;

        // Fetch cadence with a constantly asserted source, masked so no request forms.
        mask_we = 1'b1; mask_wdata = 8'hff; cyc(); mask_we = 1'b0;
        intreg = 8'hfe;
        last = -1; npulse = 0;
        for (int c = 0; c < 26; c++) begin
            cyc();
            if (oping) begin
                if (last >= 0) chk("oping period", 8'(c - last), 8'd5);
                last = c;
                npulse++;
            end
        end
        chk("oping pulse count", 8'(npulse), 8'd6);
        intreg = 8'hff;
        repeat (6) cyc();

        // Fetch set and ack clear on bit 0 in the same cycle: the bit stays pending.
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(); mask_we = 1'b0;
        chk("sw mask open", mask, 8'h00);
        intreg = 8'hfe; cyc();
        chk("sw irq", {7'd0, irq}, 8'h01);
        chk("sw vector", vector, 8'h40);
        chk("sw oping", {7'd0, oping}, 8'h01);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("sw in_service", in_service, 8'h01);
        chk("sw irq after ack", {7'd0, irq}, 8'h00);
        intreg = 8'hff; eoi = 1'b1; cyc(); eoi = 1'b0;
        chk("sw eoi", in_service, 8'h00);
        cyc();
        chk("sw set wins irq", {7'd0, irq}, 8'h01);
        chk("sw set wins vector", vector, 8'h40);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        eoi = 1'b1; cyc(); eoi = 1'b0;
        cyc();
        chk("sw drained", {7'd0, irq}, 8'h00);

        // Reset in the middle of a request aborts it immediately.
        intreg = 8'hfd;
        wait_irq("mid irq raised");
        chk("mid vector", vector, 8'h41);
        rst = 1'b1; intreg = 8'hff; cyc(); rst = 1'b0;
        chk("mid rst irq", {7'd0, irq}, 8'h00);
        chk("mid rst mask", mask, 8'hff);
        chk("mid rst vector", vector, 8'h00);
        chk("mid rst oping", {7'd0, oping}, 8'h00);

        // Sources 0 and 7 permanently active; eoi waits for pend[0] to be refetched.
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(); mask_we = 1'b0;
        intreg = 8'h7e;
        for (int n = 0; n < 4; n++) begin
            wait_irq($sformatf("serve%0d irq", n));
            chk($sformatf("serve%0d vector", n), vector, exp_served[n]);
            irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
            chk($sformatf("serve%0d in_service", n), in_service,
                (exp_served[n] == 8'h40) ? 8'h01 : 8'h80);
            repeat (6) cyc();
            eoi = 1'b1; cyc(); eoi = 1'b0;
        end
        intreg = 8'hff;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
